// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for one shared combinational ALU
//   clock, reset_n        : single clock, asynchronous active-low reset
//   reqN_valid/ready      : requester N handshake (N=0,1); ready only in IDLE for the granted side
//   reqN_a/b/fs/cin       : requester N operands, function select, carry-in
//   alu_a/b/fs/cin        : registered operands driven to the shared ALU
//   alu_f/stat/cout       : ALU result, status {V,C,N,Z}, carry-out
//   rsp_valid/ready       : response handshake; rsp_id/f/stat/cout held stable while pending
//   grant_cnt0/1          : saturating accepted-operation counters, present only when
//                           ALU_ARBITER_STATS_EN is defined, otherwise constant 0
module alu_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [4:0]       req0_fs,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [4:0]       req1_fs,
  input  logic             req1_cin,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_fs,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_f,
  input  logic [3:0]       alu_stat,
  input  logic             alu_cout,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_f,
  output logic [3:0]       rsp_stat,
  output logic             rsp_cout,
  input  logic             rsp_ready,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic last;
  logic g1;
  logic xfer;
  always_comb begin
    g1 = req1_valid & (~req0_valid | ~last);
    // reset_n gates ready so nothing looks accepted while reset is held
    req0_ready = reset_n & (state == IDLE) & req0_valid & ~g1;
    req1_ready = reset_n & (state == IDLE) & g1;
    xfer = req0_ready | req1_ready;
    state_nx = (state == IDLE && xfer) ? EXEC :
               (state == EXEC) ? RESP :
               (state == RESP && rsp_ready) ? IDLE : state;
  end
  assign rsp_valid = (state == RESP);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_fs   <= '0;
      alu_cin  <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_f    <= '0;
      rsp_stat <= '0;
      rsp_cout <= 1'b0;
    end else begin
      state <= state_nx;
      if (xfer) begin
        alu_a   <= req1_ready ? req1_a : req0_a;
        alu_b   <= req1_ready ? req1_b : req0_b;
        alu_fs  <= req1_ready ? req1_fs : req0_fs;
        alu_cin <= req1_ready ? req1_cin : req0_cin;
        rsp_id  <= req1_ready;
        last    <= req1_ready;
      end
      if (state == EXEC) begin
        rsp_f    <= alu_f;
        rsp_stat <= alu_stat;
        rsp_cout <= alu_cout;
      end
    end
`ifdef ALU_ARBITER_STATS_EN
  logic [15:0] cnt0, cnt1;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (req0_ready && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
      if (req1_ready && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
    end
  assign grant_cnt0 = cnt0;
  assign grant_cnt1 = cnt1;
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter with a behavioural ALU and scoreboard
module tb_alu_arbiter;
  localparam int W = 64;
`ifdef ALU_ARBITER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [4:0] req0_fs = '0, req1_fs = '0;
  logic req0_cin = 0, req1_cin = 0;
  logic [W-1:0] alu_a, alu_b, alu_f;
  logic [4:0] alu_fs;
  logic alu_cin, alu_cout;
  logic [3:0] alu_stat;
  logic rsp_valid, rsp_id, rsp_cout;
  logic [W-1:0] rsp_f;
  logic [3:0] rsp_stat;
  logic rsp_ready = 0;
  logic [15:0] grant_cnt0, grant_cnt1;
  int n_chk = 0, n_pass = 0;
  always #5 clock = ~clock;
  // bench ALU: returns {cout, stat{V,C,N,Z}, f}; C is left 0 in stat, carry goes to cout
  function automatic logic [W+4:0] alu_model(logic [W-1:0] a, logic [W-1:0] b, logic [4:0] fs, logic cin);
    logic [W:0] s;
    s = (fs == 5'b01000) ? {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin} :
        (fs == 5'b01001) ? {1'b0, a} + {1'b0, ~b} + 1 :
        (fs == 5'b00001) ? {1'b0, a & b} : {1'b0, a ^ b};
    return {s[W], 1'b0, 1'b0, s[W-1], s[W-1:0] == '0, s[W-1:0]};
  endfunction
  assign {alu_cout, alu_stat, alu_f} = alu_model(alu_a, alu_b, alu_fs, alu_cin);
  alu_arbiter #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_fs(req0_fs), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_fs(req1_fs), .req1_cin(req1_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fs(alu_fs), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_stat(alu_stat), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_f(rsp_f), .rsp_stat(rsp_stat), .rsp_cout(rsp_cout),
    .rsp_ready(rsp_ready), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );
  task automatic step();
    @(posedge clock); #1;
  endtask
  task automatic do_reset();
    reset_n = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    step(); step();
    reset_n = 1;
  endtask
  task automatic run_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] fs);
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_fs = fs; req1_cin = 0; end
    else begin req0_valid = 1; req0_a = a; req0_b = b; req0_fs = fs; req0_cin = 0; end
    rsp_ready = 1;
    step();
    req0_valid = 0; req1_valid = 0;
    step(); step();
  endtask
  task automatic test_reset();
    reset_n = 0; req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    step();
    @(negedge clock);
    n_chk++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL reset_ready got %b%b exp 00", req0_ready, req1_ready); else n_pass++;
    n_chk++; if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_cout !== 1'b0) $display("FAIL reset_rsp got v%b id%b c%b exp 000", rsp_valid, rsp_id, rsp_cout); else n_pass++;
    n_chk++; if (rsp_f !== '0 || rsp_stat !== '0) $display("FAIL reset_rsp_data got %h/%h exp 0/0", rsp_f, rsp_stat); else n_pass++;
    n_chk++; if (alu_a !== '0 || alu_b !== '0 || alu_fs !== '0 || alu_cin !== 1'b0) $display("FAIL reset_alu got %h %h %h %b exp 0", alu_a, alu_b, alu_fs, alu_cin); else n_pass++;
    n_chk++; if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0) $display("FAIL reset_cnt got %0d %0d exp 0 0", grant_cnt0, grant_cnt1); else n_pass++;
    step();
    reset_n = 1;
    @(negedge clock);
    n_chk++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL reset_first_grant got %b%b exp 10", req0_ready, req1_ready); else n_pass++;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    step();
  endtask
  task automatic test_single();
    do_reset();
    req0_valid = 1; req0_a = 5; req0_b = 3; req0_fs = 5'b01000; req0_cin = 0; rsp_ready = 1;
    @(negedge clock);
    n_chk++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL single_ready got %b%b exp 10", req0_ready, req1_ready); else n_pass++;
    step();
    req0_valid = 0;
    @(negedge clock);
    n_chk++; if (rsp_valid !== 1'b0 || alu_a !== 64'd5 || alu_b !== 64'd3) $display("FAIL single_exec got v%b a%0d b%0d exp v0 a5 b3", rsp_valid, alu_a, alu_b); else n_pass++;
    step();
    @(negedge clock);
    n_chk++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_f !== 64'd8) $display("FAIL single_rsp got v%b id%b f%0d exp v1 id0 f8", rsp_valid, rsp_id, rsp_f); else n_pass++;
    step();
    @(negedge clock);
    n_chk++; if (rsp_valid !== 1'b0) $display("FAIL single_done got %b exp 0", rsp_valid); else n_pass++;
    step();
  endtask
  task automatic test_status();
    do_reset();
    run_op(1'b0, 64'd7, 64'd7, 5'b01001);
    n_chk++; if (rsp_stat !== 4'b0001 || rsp_cout !== 1'b1 || rsp_f !== '0) $display("FAIL status got stat%b c%b f%h exp 0001 1 0", rsp_stat, rsp_cout, rsp_f); else n_pass++;
  endtask
  task automatic test_back_to_back();
    int cyc[4];
    bit ids[4];
    int n = 0;
    do_reset();
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    req0_a = 100; req0_b = 1; req0_fs = 5'b01000; req1_a = 200; req1_b = 2; req1_fs = 5'b01000;
    for (int i = 0; i < 20 && n < 4; i++) begin
      @(negedge clock);
      if (rsp_valid) begin cyc[n] = i; ids[n] = rsp_id; n++; end
      step();
    end
    req0_valid = 0; req1_valid = 0;
    n_chk++; if (n !== 4) $display("FAIL b2b_count got %0d exp 4", n); else n_pass++;
    for (int i = 0; i < 4 && i < n; i++) begin
      n_chk++; if (ids[i] !== i[0]) $display("FAIL b2b_id%0d got %b exp %b", i, ids[i], i[0]); else n_pass++;
      if (i > 0) begin
        n_chk++; if (cyc[i] - cyc[i-1] != 3) $display("FAIL b2b_gap%0d got %0d exp 3", i, cyc[i] - cyc[i-1]); else n_pass++;
      end
    end
    step(); step(); step();
  endtask
  task automatic test_backpressure();
    int bad = 0;
    do_reset();
    req0_valid = 1; req0_a = 11; req0_b = 22; req0_fs = 5'b01000; req0_cin = 0; rsp_ready = 0;
    step();
    req0_valid = 0; req1_valid = 1; req1_a = 1; req1_b = 1; req1_fs = 5'b01000;
    @(negedge clock);
    n_chk++; if (req1_ready !== 1'b0) $display("FAIL bp_exec_ready got %b exp 0", req1_ready); else n_pass++;
    step();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (rsp_valid !== 1'b1 || rsp_f !== 64'd33 || req1_ready !== 1'b0) bad++;
      step();
    end
    n_chk++; if (bad != 0) $display("FAIL bp_hold got %0d bad cycles exp 0", bad); else n_pass++;
    rsp_ready = 1;
    @(negedge clock);
    n_chk++; if (rsp_valid !== 1'b1 || req1_ready !== 1'b0) $display("FAIL bp_handshake got v%b r1%b exp 1 0", rsp_valid, req1_ready); else n_pass++;
    step();
    @(negedge clock);
    n_chk++; if (req1_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL bp_accept got r1%b v%b exp 1 0", req1_ready, rsp_valid); else n_pass++;
    req1_valid = 0;
    step();
  endtask
  task automatic test_reset_exec();
    int seen = 0;
    do_reset();
    req0_valid = 1; req0_a = 1; req0_b = 2; req0_fs = 5'b01000; rsp_ready = 1;
    step();
    req0_valid = 0;
    #2 reset_n = 0;
    #1;
    n_chk++; if (rsp_valid !== 1'b0 || rsp_f !== '0 || alu_a !== '0 || alu_b !== '0) $display("FAIL rexec_async got v%b f%h a%h b%h exp 0", rsp_valid, rsp_f, alu_a, alu_b); else n_pass++;
    step();
    reset_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (rsp_valid) seen++;
      step();
    end
    n_chk++; if (seen != 0) $display("FAIL rexec_no_rsp got %0d exp 0", seen); else n_pass++;
    req1_valid = 1; req1_a = 4; req1_b = 4; req1_fs = 5'b01000; req1_cin = 0;
    @(negedge clock);
    n_chk++; if (req1_ready !== 1'b1) $display("FAIL rexec_accept got %b exp 1", req1_ready); else n_pass++;
    step();
    req1_valid = 0;
    step();
    @(negedge clock);
    n_chk++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_f !== 64'd8) $display("FAIL rexec_rsp got v%b id%b f%0d exp 1 1 8", rsp_valid, rsp_id, rsp_f); else n_pass++;
    step();
  endtask
  task automatic test_stats();
    bit seq[5] = '{0, 0, 1, 0, 1};
    do_reset();
    for (int i = 0; i < 5; i++) run_op(seq[i], W'(i), W'(i + 1), 5'b01000);
    @(negedge clock);
    n_chk++; if (grant_cnt0 !== (STATS ? 16'd3 : 16'd0) || grant_cnt1 !== (STATS ? 16'd2 : 16'd0)) $display("FAIL stats got %0d %0d exp %0d %0d", grant_cnt0, grant_cnt1, STATS ? 3 : 0, STATS ? 2 : 0); else n_pass++;
    step();
  endtask
  task automatic test_random();
    int phase = 0;
    bit m_last = 1, m_id = 0, e0, e1;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic [W+4:0] m_exp = '0;
    int c0 = 0, c1 = 0, bad = 0;
    logic [4:0] fs_tab[4] = '{5'b01000, 5'b01001, 5'b00001, 5'b00011};
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 3) != 0); req1_valid = ($urandom_range(0, 3) != 0);
      req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom}; req0_fs = fs_tab[$urandom_range(0, 3)]; req0_cin = 1'($urandom);
      req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom}; req1_fs = fs_tab[$urandom_range(0, 3)]; req1_cin = 1'($urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
      @(negedge clock);
      e1 = (phase == 0) && req1_valid && (!req0_valid || !m_last);
      e0 = (phase == 0) && req0_valid && !e1;
      n_chk++; if (req0_ready !== e0 || req1_ready !== e1) begin bad++; $display("FAIL rnd_ready c%0d got %b%b exp %b%b", i, req0_ready, req1_ready, e0, e1); end else n_pass++;
      n_chk++; if (rsp_valid !== (phase == 2)) begin bad++; $display("FAIL rnd_valid c%0d got %b exp %b", i, rsp_valid, phase == 2); end else n_pass++;
      n_chk++; if (alu_a !== m_a || alu_b !== m_b) begin bad++; $display("FAIL rnd_alu c%0d got %h %h exp %h %h", i, alu_a, alu_b, m_a, m_b); end else n_pass++;
      n_chk++; if (grant_cnt0 !== (STATS ? 16'(c0) : 16'd0) || grant_cnt1 !== (STATS ? 16'(c1) : 16'd0)) begin bad++; $display("FAIL rnd_cnt c%0d got %0d %0d", i, grant_cnt0, grant_cnt1); end else n_pass++;
      if (phase == 2) begin
        n_chk++; if (rsp_id !== m_id || rsp_f !== m_exp[W-1:0] || rsp_stat !== m_exp[W+3:W] || rsp_cout !== m_exp[W+4]) begin
          bad++; $display("FAIL rnd_rsp c%0d got id%b f%h s%b c%b exp id%b f%h s%b c%b", i, rsp_id, rsp_f, rsp_stat, rsp_cout, m_id, m_exp[W-1:0], m_exp[W+3:W], m_exp[W+4]);
        end else n_pass++;
      end
      if (e0 || e1) begin
        m_id = e1; m_last = e1;
        m_a = e1 ? req1_a : req0_a; m_b = e1 ? req1_b : req0_b;
        m_exp = e1 ? alu_model(req1_a, req1_b, req1_fs, req1_cin) : alu_model(req0_a, req0_b, req0_fs, req0_cin);
        if (e1) c1++; else c0++;
        phase = 1;
      end else if (phase == 1) phase = 2;
      else if (phase == 2 && rsp_ready) phase = 0;
      step();
      if (bad > 10) break;
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    step(); step(); step();
  endtask
  initial begin
    step();
    test_reset();
    test_single();
    test_status();
    test_back_to_back();
    test_backpressure();
    test_reset_exec();
    test_stats();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
